// File: rtl/adc_frame_deserializer.sv
// Serial ADC frame deserializer: shifts one MSB-first frame in while cs is high,
// extracts the sample field and hands it off on a valid/ready interface.
module adc_frame_deserializer #(
    parameter int FRAME_BITS = 16,
    parameter int LEAD_BITS  = 4,
    parameter int DATA_W     = 12,
    parameter int SIGNED_OUT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs,
    input  logic              bit_pulse,
    input  logic              miso,
    output logic [DATA_W-1:0] sample,
    output logic              valid,
    input  logic              ready,
    output logic              overrun,
    output logic              short_frame
);

    localparam int CNT_W  = $clog2(FRAME_BITS + 1);
    // Lead bits fall off the top after a full frame, so only the low part is stored.
    localparam int KEEP_W = FRAME_BITS - LEAD_BITS;
    localparam logic [DATA_W-1:0] MSB_FLIP = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        WAIT_CS,
        LOAD
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              cs_q;
    logic [KEEP_W-1:0] shreg;
    logic [CNT_W-1:0]  bitcnt;

    logic              cs_rise;
    logic              shift_en;
    logic              last_bit;
    logic [DATA_W-1:0] field;
    logic [DATA_W-1:0] sample_nxt;

    assign cs_rise    = cs & ~cs_q;
    assign shift_en   = (state == SHIFT) && cs && bit_pulse && (bitcnt != CNT_W'(FRAME_BITS));
    assign last_bit   = (bitcnt == CNT_W'(FRAME_BITS - 1));
    assign field      = shreg[KEEP_W-1 -: DATA_W];
    assign sample_nxt = (SIGNED_OUT != 0) ? (field ^ MSB_FLIP) : field;

    always_comb begin
        // NOTE: default assigned first so no path leaves state_nxt unassigned (no latch).
        state_nxt = state;
        case (state)
            IDLE:    if (cs_rise) state_nxt = SHIFT;
            SHIFT: begin
                if (shift_en && last_bit) state_nxt = WAIT_CS;
                else if (!cs)             state_nxt = IDLE;
            end
            WAIT_CS: if (!cs) state_nxt = LOAD;
            LOAD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: all sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cs_q        <= 1'b0;
            shreg       <= '0;
            bitcnt      <= '0;
            sample      <= '0;
            valid       <= 1'b0;
            overrun     <= 1'b0;
            short_frame <= 1'b0;
        end else begin
            state       <= state_nxt;
            cs_q        <= cs;
            short_frame <= (state == SHIFT) && !cs;
            overrun     <= (state == LOAD) && valid && !ready;

            if (state == IDLE && cs_rise) begin
                shreg  <= '0;
                bitcnt <= '0;
            end else if (shift_en) begin
                shreg  <= {shreg[KEEP_W-2:0], miso};
                bitcnt <= bitcnt + CNT_W'(1);
            end

            // A load always wins over a same-cycle consume: the new sample takes its place.
            if (state == LOAD) begin
                sample <= sample_nxt;
                valid  <= 1'b1;
            end else if (valid && ready) begin
                valid  <= 1'b0;
            end
        end
    end

endmodule
